// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional even/odd parity, stop bit.
// One clk cycle per bit time; TX_OUT and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYPE,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  // Handshake: Data_Valid is a ready-less request; it is taken on a rising
  // edge only while the FSM is IDLE and silently dropped in every other state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    tx_d;
  logic                    busy_d;
  logic                    accept;
  logic                    last_bit;

  assign accept    = (state == IDLE) && Data_Valid;
  assign last_bit  = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Data_Valid) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state != IDLE);
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[cnt];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  // Frame registers are only loaded on accept, so mid-frame input changes are inert.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      cnt       <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYPE;
      end
      if (state == DATA) begin
        cnt <= last_bit ? '0 : cnt + 1'b1;
      end else if (state == START) begin
        cnt <= '0;
      end
      TX_OUT <= tx_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: each request queues the expected per-cycle
// {busy, TX_OUT} timeline and a negedge monitor pops and compares it.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYPE;
  logic       TX_OUT;
  logic       busy;
  logic [2:0] state_dbg;

  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;
  int         vec_cnt;
  int         err_cnt;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYPE   (PAR_TYPE),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // monitor: one expected {busy,tx} per cycle, idle line when nothing is queued
  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      else                  mon_exp = 2'b01;
      check("line", 16'({busy, TX_OUT}), 16'(mon_exp));
    end
  end

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
    if (pe) exp_q.push_back({1'b1, (^d) ^ pt});
    exp_q.push_back(2'b11);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // one-cycle request; returns 1ns after the edge following the accept edge
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input bit scramble);
    wait_drain();
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYPE   = pt;
    Data_Valid = 1'b1;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    push_frame(d, pe, pt);
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    @(posedge clk);
    #1;
    if (scramble) begin
      P_DATA   = 8'hFF;
      PAR_EN   = ~pe;
      PAR_TYPE = ~pt;
    end
  endtask

  task automatic send_held(input logic [7:0] d, input int frames);
    wait_drain();
    P_DATA     = d;
    PAR_EN     = 1'b0;
    PAR_TYPE   = 1'b0;
    Data_Valid = 1'b1;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    push_frame(d, 1'b0, 1'b0);
    for (int k = 1; k < frames; k++) begin
      exp_q.push_back(2'b01);
      push_frame(d, 1'b0, 1'b0);
    end
    repeat (11 * (frames - 1) + 1) @(posedge clk);
    #1;
    Data_Valid = 1'b0;
  endtask

  task automatic pulse_request(input logic [7:0] d);
    P_DATA     = d;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYPE   = 1'b0;
    rst        = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset_tx", 16'(TX_OUT), 16'd1);
    check("reset_busy", 16'(busy), 16'd0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(3);

    // even parity 0xA5: 0,1,0,1,0,0,1,0,1,0,1
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    // odd parity 0x07, inputs scrambled after accept
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    // no parity 0x00
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);

    // request while busy must be dropped
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    pulse_request(8'h3C);
    wait_drain();
    idle_cycles(15);

    // held Data_Valid: back-to-back frames with one idle mark bit between
    send_held(8'h55, 3);
    wait_drain();
    idle_cycles(5);

    // a few random frames
    for (int r = 0; r < 4; r++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
    end

    // reset during data bit 3 of a 0xA5 frame
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx", 16'(TX_OUT), 16'd1);
    check("midrst_busy", 16'(busy), 16'd0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);

    wait_drain();
    idle_cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
